// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a synchronous instruction ROM and
// loads the IF/ID register, with stall hold and redirect/flush from a later stage.
module fetch_stage #(
  parameter int                     PC_WIDTH    = 64,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0]    PC_STEP     = PC_WIDTH'(1),
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'hD503201F)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_en,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid,
  output logic [31:0]            fetch_count
);

  logic [PC_WIDTH-1:0]    fetch_pc_reg, fetch_pc_next;
  logic [PC_WIDTH-1:0]    pend_pc_reg, pend_pc_next;
  logic                   pend_valid_reg, pend_valid_next;
  logic [PC_WIDTH-1:0]    if_id_pc_reg, if_id_pc_next;
  logic [INSTR_WIDTH-1:0] if_id_instr_reg, if_id_instr_next;
  logic                   if_id_valid_reg, if_id_valid_next;
  logic [31:0]            fetch_count_reg, fetch_count_next;
  logic                   hold;

  assign hold = stall && !redirect_en;

  // Replaying the pending address while stalled keeps imem_data paired with pend_pc.
  assign imem_addr = hold ? pend_pc_reg : fetch_pc_reg;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    pend_pc_next     = pend_pc_reg;
    pend_valid_next  = pend_valid_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_instr_next = if_id_instr_reg;
    if_id_valid_next = if_id_valid_reg;
    fetch_count_next = fetch_count_reg;
    if (redirect_en) begin
      fetch_pc_next    = redirect_pc;
      pend_valid_next  = 1'b0;
      if_id_pc_next    = '0;
      if_id_instr_next = NOP_INSTR;
      if_id_valid_next = 1'b0;
    end else if (!stall) begin
      fetch_pc_next    = fetch_pc_reg + PC_STEP;
      pend_pc_next     = fetch_pc_reg;
      pend_valid_next  = 1'b1;
      if_id_pc_next    = pend_pc_reg;
      if_id_instr_next = pend_valid_reg ? imem_data : NOP_INSTR;
      if_id_valid_next = pend_valid_reg;
      fetch_count_next = fetch_count_reg + 32'(pend_valid_reg);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      pend_pc_reg     <= '0;
      pend_valid_reg  <= 1'b0;
      if_id_pc_reg    <= '0;
      if_id_instr_reg <= NOP_INSTR;
      if_id_valid_reg <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      pend_pc_reg     <= pend_pc_next;
      pend_valid_reg  <= pend_valid_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_valid_reg <= if_id_valid_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign if_id_pc    = if_id_pc_reg;
  assign if_id_instr = if_id_instr_reg;
  assign if_id_valid = if_id_valid_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, wrap-around sequence on a second
// instance, and random stall/redirect/reset traffic against a stream-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;
  localparam logic [63:0] ONES = {64{1'b1}};

  logic        clock = 1'b0;
  logic        reset, stall, redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic        reset1;
  logic [63:0] imem_addr1;
  logic [31:0] imem_data1;
  logic [63:0] if_id_pc1;
  logic [31:0] if_id_instr1;
  logic        if_id_valid1;
  logic [31:0] fetch_count1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return 32'h100 + a[31:0];
  endfunction

  always @(posedge clock) begin
    imem_data  <= rom_word(imem_addr);
    imem_data1 <= rom_word(imem_addr1);
  end

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(ONES)) dut_wrap (
    .clock(clock), .reset(reset1), .stall(1'b0), .redirect_en(1'b0),
    .redirect_pc(64'd0), .imem_addr(imem_addr1), .imem_data(imem_data1),
    .if_id_pc(if_id_pc1), .if_id_instr(if_id_instr1), .if_id_valid(if_id_valid1),
    .fetch_count(fetch_count1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, st, rd;
    logic [63:0] rpc;
    logic        chk_addr;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic        chk_pc;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic rst, st, rd, input logic [63:0] rpc,
                              input logic chk_addr, input logic [63:0] exp_addr,
                              input logic v, input logic chk_pc, input logic [63:0] pc,
                              input logic [31:0] instr, input logic [31:0] cnt);
    vec_t r;
    r.rst = rst; r.st = st; r.rd = rd; r.rpc = rpc;
    r.chk_addr = chk_addr; r.exp_addr = exp_addr;
    r.exp_valid = v; r.chk_pc = chk_pc; r.exp_pc = pc;
    r.exp_instr = instr; r.exp_cnt = cnt;
    return r;
  endfunction

  // Drive inputs away from the edge, optionally check imem_addr, then take one edge.
  task automatic apply(input logic rst, st, rd, input logic [63:0] rpc,
                       input logic chk_addr, input logic [63:0] exp_addr);
    @(negedge clock);
    reset = rst; stall = st; redirect_en = rd; redirect_pc = rpc;
    #1;
    if (chk_addr) check("imem_addr", imem_addr, exp_addr);
    @(posedge clock);
    #1;
  endtask

  // Stream-level model: next instruction address, pending bubble slots, delivered count.
  logic [63:0] m_pc;
  int          m_bub;
  logic        m_from_reset;
  logic [31:0] m_cnt;
  logic        m_valid, m_pc_known;
  logic [63:0] m_opc;
  logic [31:0] m_oinstr;

  task automatic model_step(input logic rst, st, rd, input logic [63:0] rpc);
    if (rst) begin
      m_pc = 64'd0; m_bub = 1; m_from_reset = 1'b1; m_cnt = 0;
      m_valid = 0; m_opc = 0; m_oinstr = NOP; m_pc_known = 1;
    end else if (rd) begin
      m_pc = rpc; m_bub = 1; m_from_reset = 1'b0;
      m_valid = 0; m_opc = 0; m_oinstr = NOP; m_pc_known = 1;
    end else if (!st) begin
      if (m_bub > 0) begin
        m_bub--;
        m_valid = 0; m_opc = 0; m_oinstr = NOP; m_pc_known = m_from_reset;
      end else begin
        m_valid = 1; m_opc = m_pc; m_oinstr = rom_word(m_pc); m_pc_known = 1;
        m_pc = m_pc + 64'd1;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  initial begin
    reset = 1; stall = 0; redirect_en = 0; redirect_pc = 0; reset1 = 1;

    vecs[0]  = mk(1,0,0,0,     0,0,    0,1,0,    NOP,        0);
    vecs[1]  = mk(0,0,0,0,     0,0,    0,1,0,    NOP,        0);
    vecs[2]  = mk(0,0,0,0,     0,0,    1,1,0,    32'h100,    1);
    vecs[3]  = mk(0,0,0,0,     0,0,    1,1,1,    32'h101,    2);
    vecs[4]  = mk(0,0,0,0,     0,0,    1,1,2,    32'h102,    3);
    vecs[5]  = mk(0,0,0,0,     0,0,    1,1,3,    32'h103,    4);
    vecs[6]  = mk(0,0,0,0,     0,0,    1,1,4,    32'h104,    5);
    vecs[7]  = mk(0,0,0,0,     0,0,    1,1,5,    32'h105,    6);
    vecs[8]  = mk(0,1,0,0,     1,6,    1,1,5,    32'h105,    6);
    vecs[9]  = mk(0,1,0,0,     1,6,    1,1,5,    32'h105,    6);
    vecs[10] = mk(0,1,0,0,     1,6,    1,1,5,    32'h105,    6);
    vecs[11] = mk(0,0,0,0,     0,0,    1,1,6,    32'h106,    7);
    vecs[12] = mk(0,0,0,0,     0,0,    1,1,7,    32'h107,    8);
    vecs[13] = mk(0,0,0,0,     0,0,    1,1,8,    32'h108,    9);
    vecs[14] = mk(0,0,0,0,     0,0,    1,1,9,    32'h109,    10);
    vecs[15] = mk(1,1,0,0,     0,0,    0,1,0,    NOP,        0);
    vecs[16] = mk(0,0,0,0,     0,0,    0,1,0,    NOP,        0);
    vecs[17] = mk(0,0,0,0,     0,0,    1,1,0,    32'h100,    1);
    vecs[18] = mk(0,0,0,0,     0,0,    1,1,1,    32'h101,    2);
    vecs[19] = mk(0,0,0,0,     0,0,    1,1,2,    32'h102,    3);
    vecs[20] = mk(0,0,0,0,     0,0,    1,1,3,    32'h103,    4);
    vecs[21] = mk(0,0,1,64'h40,0,0,    0,1,0,    NOP,        4);
    vecs[22] = mk(0,0,0,0,     0,0,    0,0,0,    NOP,        4);
    vecs[23] = mk(0,0,0,0,     0,0,    1,1,64'h40,32'h140,   5);
    vecs[24] = mk(0,0,0,0,     0,0,    1,1,64'h41,32'h141,   6);
    vecs[25] = mk(0,1,1,64'h10,1,64'h43,0,1,0,   NOP,        6);
    vecs[26] = mk(0,0,0,0,     0,0,    0,0,0,    NOP,        6);
    vecs[27] = mk(0,0,0,0,     0,0,    1,1,64'h10,32'h110,   7);
    vecs[28] = mk(0,0,0,0,     0,0,    1,1,64'h11,32'h111,   8);

    for (int i = 0; i < 29; i++) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].rd, vecs[i].rpc,
            vecs[i].chk_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d valid", i), {63'd0, if_id_valid}, {63'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d instr", i), {32'd0, if_id_instr}, {32'd0, vecs[i].exp_instr});
      check($sformatf("vec%0d count", i), {32'd0, fetch_count}, {32'd0, vecs[i].exp_cnt});
      if (vecs[i].chk_pc) check($sformatf("vec%0d pc", i), if_id_pc, vecs[i].exp_pc);
      $display("vec %0d: valid=%0b pc=%h instr=%h count=%0d", i, if_id_valid, if_id_pc,
               if_id_instr, fetch_count);
    end

    // PC wrap-around on the instance that starts at all-ones.
    @(negedge clock); reset1 = 1;
    @(posedge clock); #1;
    @(negedge clock); reset1 = 0; #1;
    check("wrap addr0", imem_addr1, ONES);
    @(posedge clock); #1;
    check("wrap valid1", {63'd0, if_id_valid1}, 64'd0);
    check("wrap addr1", imem_addr1, 64'd0);
    @(posedge clock); #1;
    check("wrap valid2", {63'd0, if_id_valid1}, 64'd1);
    check("wrap pc2", if_id_pc1, ONES);
    check("wrap instr2", {32'd0, if_id_instr1}, 64'h0FF);
    check("wrap addr2", imem_addr1, 64'd1);
    $display("wrap: pc=%h instr=%h", if_id_pc1, if_id_instr1);
    @(posedge clock); #1;
    check("wrap pc3", if_id_pc1, 64'd0);
    check("wrap instr3", {32'd0, if_id_instr1}, 64'h100);
    check("wrap count3", {32'd0, fetch_count1}, 64'd2);
    $display("wrap: pc=%h instr=%h count=%0d", if_id_pc1, if_id_instr1, fetch_count1);

    // Random traffic against the model.
    apply(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic r_rst, r_st, r_rd;
      logic [63:0] r_pc;
      r_rst = ($urandom_range(0, 99) < 2);
      r_rd  = ($urandom_range(0, 99) < 10);
      r_st  = ($urandom_range(0, 99) < 25);
      r_pc  = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) r_pc = 64'($urandom_range(0, 255));
      apply(r_rst, r_st, r_rd, r_pc, 0, 0);
      model_step(r_rst, r_st, r_rd, r_pc);
      check($sformatf("rand%0d valid", n), {63'd0, if_id_valid}, {63'd0, m_valid});
      check($sformatf("rand%0d instr", n), {32'd0, if_id_instr}, {32'd0, m_oinstr});
      check($sformatf("rand%0d count", n), {32'd0, fetch_count}, {32'd0, m_cnt});
      if (m_pc_known) check($sformatf("rand%0d pc", n), if_id_pc, m_opc);
      $display("rand %0d: rst=%0b st=%0b rd=%0b valid=%0b pc=%h instr=%h count=%0d",
               n, r_rst, r_st, r_rd, if_id_valid, if_id_pc, if_id_instr, fetch_count);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
